// File: rtl/hex_display_pkg.sv
// ---------------------------------------------------------------------------
// hex_display_pkg
//
// Shared definitions for the seven-segment scan front end:
//   - scan_state_e : sweep FSM states (the step index is held separately)
//   - SEL_*        : digit-select codes driven to the upstream multiplexer
//   - SEG_BLANK / SEG_MINUS : active-low segment patterns {g,f,e,d,c,b,a}
//   - stepToSel()  : maps sweep step 0..3 to its digit-select code
// ---------------------------------------------------------------------------
package hex_display_pkg;

    // Sweep phases; which digit is being handled lives in a separate step index
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_COMMIT = 2'd3
    } scan_state_e;

    localparam logic [2:0] SEL_ONES      = 3'd0;
    localparam logic [2:0] SEL_TENS      = 3'd1;
    localparam logic [2:0] SEL_HUNDREDS  = 3'd3;
    localparam logic [2:0] SEL_THOUSANDS = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // The multiplexer skips code 2, so the step index cannot be used directly
    function automatic logic [2:0] stepToSel(input logic [1:0] step);
        logic [2:0] selCode;
        case (step)
            2'd0: selCode = SEL_ONES;
            2'd1: selCode = SEL_TENS;
            2'd2: selCode = SEL_HUNDREDS;
            2'd3: selCode = SEL_THOUSANDS;
        endcase
        return selCode;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------
// seg_decoder
//
// Combinational BCD to seven-segment decoder, active-low, bit order
// {g,f,e,d,c,b,a}. Codes 10..15 are not valid BCD and decode to blank.
//
// Ports:
//   bcd_i [3:0] : BCD digit
//   seg_o [6:0] : active-low segment pattern
// ---------------------------------------------------------------------------
module seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Plain lookup; anything outside 0..9 shows nothing rather than garbage
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = 7'b1000000;
            4'd1: seg_o = 7'b1111001;
            4'd2: seg_o = 7'b0100100;
            4'd3: seg_o = 7'b0110000;
            4'd4: seg_o = 7'b0011001;
            4'd5: seg_o = 7'b0010010;
            4'd6: seg_o = 7'b0000010;
            4'd7: seg_o = 7'b1111000;
            4'd8: seg_o = 7'b0000000;
            4'd9: seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scan.sv
// ---------------------------------------------------------------------------
// hex_display_scan
//
// Sweeps the digit-select code through ones/tens/hundreds/thousands, samples
// the BCD digit (and the sign with the ones digit) returned by the upstream
// multiplexer into shadow registers, then decodes and commits all six HEX
// outputs in a single cycle so the display never shows a half-updated value.
// A sweep starts on update, on the periodic refresh tick, or on a request
// that arrived while a previous sweep was still running.
//
// Parameters:
//   REFRESH_CYCLES : clk cycles between automatic sweeps (>= 16)
//   BLANK_ZEROS    : 1 blanks leading zeros on hex3..hex1
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   update         : sweep request (level, sampled every cycle)
//   digit [3:0]    : BCD digit for the current sel
//   sign           : 1 = negative value
//   sel [2:0]      : digit-select code to the multiplexer
//   hex0..hex5     : active-low segments {g,f,e,d,c,b,a}
//   busy           : sweep in progress
//   done           : one-cycle pulse when new hex values appear
// ---------------------------------------------------------------------------
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 500000,
    parameter bit BLANK_ZEROS    = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic [3:0] digit,
    input  logic       sign,
    output logic [2:0] sel,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

    scan_state_e   state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] refreshCount_q, refreshCount_d;
    logic [3:0]    shadowDigit_q [4];
    logic          shadowSign_q;
    logic [6:0]    hex0_q, hex1_q, hex2_q, hex3_q, hex4_q;
    logic          done_q;

    logic          refreshTick;
    logic          request;
    logic          trigger;
    logic [6:0]    segRaw [4];
    logic [6:0]    hex0_d, hex1_d, hex2_d, hex3_d, hex4_d;
    logic          thousandsZero, hundredsZero, tensZero;

    // Free-running refresh counter; the tick is its last value before wrap
    assign refreshTick    = (refreshCount_q == REFRESH_LAST);
    assign refreshCount_d = refreshTick ? '0 : refreshCount_q + CW'(1);

    // A fresh request, or one remembered from a sweep that was still running
    assign request = update | refreshTick;
    assign trigger = request | pending_q;

    // Sweep sequencing: two cycles per digit (settle, then sample), then commit.
    // Requests seen outside IDLE collapse into a single pending flag.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d   = ST_SETTLE;
                    step_d    = 2'd0;
                    pending_d = 1'b0;
                end
            end
            ST_SETTLE: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (step_q == 2'd3) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_SETTLE;
                    step_d  = step_q + 2'd1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if ((state_q != ST_IDLE) && request) begin
            pending_d = 1'b1;
        end
    end

    // One decoder per shadow digit; their outputs only matter during COMMIT
    for (genvar i = 0; i < 4; i++) begin : gDecode
        seg_decoder uSegDecoder (
            .bcd_i (shadowDigit_q[i]),
            .seg_o (segRaw[i])
        );
    end

    // Leading-zero blanking works from the top digit down; ones always shows
    always_comb begin
        thousandsZero = (shadowDigit_q[3] == 4'd0);
        hundredsZero  = (shadowDigit_q[2] == 4'd0);
        tensZero      = (shadowDigit_q[1] == 4'd0);
        hex0_d = segRaw[0];
        hex1_d = segRaw[1];
        hex2_d = segRaw[2];
        hex3_d = segRaw[3];
        if (BLANK_ZEROS && thousandsZero) begin
            hex3_d = SEG_BLANK;
        end
        if (BLANK_ZEROS && thousandsZero && hundredsZero) begin
            hex2_d = SEG_BLANK;
        end
        if (BLANK_ZEROS && thousandsZero && hundredsZero && tensZero) begin
            hex1_d = SEG_BLANK;
        end
        hex4_d = shadowSign_q ? SEG_MINUS : SEG_BLANK;
    end

    // State, shadow capture and the atomic output commit. The HEX registers
    // load only in COMMIT, so partially sampled values are never visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            step_q           <= 2'd0;
            pending_q        <= 1'b0;
            refreshCount_q   <= '0;
            shadowDigit_q[0] <= 4'd0;
            shadowDigit_q[1] <= 4'd0;
            shadowDigit_q[2] <= 4'd0;
            shadowDigit_q[3] <= 4'd0;
            shadowSign_q     <= 1'b0;
            hex0_q           <= SEG_BLANK;
            hex1_q           <= SEG_BLANK;
            hex2_q           <= SEG_BLANK;
            hex3_q           <= SEG_BLANK;
            hex4_q           <= SEG_BLANK;
            done_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            pending_q      <= pending_d;
            refreshCount_q <= refreshCount_d;
            if (state_q == ST_SAMPLE) begin
                shadowDigit_q[step_q] <= digit;
                if (step_q == 2'd0) begin
                    shadowSign_q <= sign;
                end
            end
            if (state_q == ST_COMMIT) begin
                hex0_q <= hex0_d;
                hex1_q <= hex1_d;
                hex2_q <= hex2_d;
                hex3_q <= hex3_d;
                hex4_q <= hex4_d;
            end
            done_q <= (state_q == ST_COMMIT);
        end
    end

    // sel is held for both the settle and sample cycle of a step, else ones
    always_comb begin
        sel = SEL_ONES;
        if ((state_q == ST_SETTLE) || (state_q == ST_SAMPLE)) begin
            sel = stepToSel(step_q);
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hex0 = hex0_q;
    assign hex1 = hex1_q;
    assign hex2 = hex2_q;
    assign hex3 = hex3_q;
    assign hex4 = hex4_q;
    assign hex5 = SEG_BLANK;

endmodule

// File: tb/tb_hex_display_scan.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scan
//
// Drives two scanners from a shared behavioural multiplexer: instance A has a
// refresh period longer than the whole run and blanks leading zeros; instance
// B refreshes every 16 cycles and shows all digits. Expected displays come
// from decimal arithmetic on the magnitude and sign being presented.
// ---------------------------------------------------------------------------
module tb_hex_display_scan;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic update = 1'b0;
    logic updateB = 1'b0;

    int unsigned mag = 0;
    logic        neg = 1'b0;

    logic [3:0] digitA, digitB;
    logic [2:0] selA, selB;
    logic [6:0] hA0, hA1, hA2, hA3, hA4, hA5;
    logic [6:0] hB0, hB1, hB2, hB3, hB4, hB5;
    logic       busyA, doneA, busyB, doneB;

    int checks = 0;
    int errors = 0;

    logic [41:0] lastShownA = {42{1'b1}};

    always #5 clk = ~clk;

    // Upstream multiplexer: picks one decimal digit of the magnitude by sel;
    // the unused code returns junk so driving it would show up
    function automatic logic [3:0] muxModel(input int unsigned m, input logic [2:0] s);
        case (s)
            3'd0:    return 4'(m % 10);
            3'd1:    return 4'((m / 10) % 10);
            3'd3:    return 4'((m / 100) % 10);
            3'd4:    return 4'((m / 1000) % 10);
            default: return 4'hE;
        endcase
    endfunction

    always_comb digitA = muxModel(mag, selA);
    always_comb digitB = muxModel(mag, selB);

    hex_display_scan #(.REFRESH_CYCLES(200000), .BLANK_ZEROS(1'b1)) dutA (
        .clk(clk), .reset(reset), .update(update), .digit(digitA), .sign(neg),
        .sel(selA), .hex0(hA0), .hex1(hA1), .hex2(hA2), .hex3(hA3), .hex4(hA4),
        .hex5(hA5), .busy(busyA), .done(doneA)
    );

    hex_display_scan #(.REFRESH_CYCLES(16), .BLANK_ZEROS(1'b0)) dutB (
        .clk(clk), .reset(reset), .update(updateB), .digit(digitB), .sign(neg),
        .sel(selB), .hex0(hB0), .hex1(hB1), .hex2(hB2), .hex3(hB3), .hex4(hB4),
        .hex5(hB5), .busy(busyB), .done(doneB)
    );

    // Segment patterns for a decimal digit, active low {g..a}
    function automatic logic [6:0] segOf(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Whole display {hex5..hex0} for a magnitude/sign; leading zeros are just
    // "magnitude below 10/100/1000"
    function automatic logic [41:0] refHex(input int unsigned m, input logic n, input bit blankZeros);
        logic [6:0] h [6];
        h[0] = segOf(m % 10);
        h[1] = (blankZeros && m < 10)   ? 7'b1111111 : segOf((m / 10) % 10);
        h[2] = (blankZeros && m < 100)  ? 7'b1111111 : segOf((m / 100) % 10);
        h[3] = (blankZeros && m < 1000) ? 7'b1111111 : segOf((m / 1000) % 10);
        h[4] = n ? 7'b0111111 : 7'b1111111;
        h[5] = 7'b1111111;
        return {h[5], h[4], h[3], h[2], h[1], h[0]};
    endfunction

    // Every comparison in the bench goes through here
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Move to 1 time unit after the next rising edge, where outputs are stable
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One update-triggered sweep on A, checked cycle by cycle. With tear set,
    // the magnitude switches to m1 after the tens digit has been sampled.
    task automatic applyStimulus(input string tag, input int unsigned m0, input logic n0,
                                 input bit tear, input int unsigned m1);
        logic [2:0] selSeq [4];
        logic [2:0] expSel;
        int unsigned shown;
        selSeq[0] = 3'd0; selSeq[1] = 3'd1; selSeq[2] = 3'd3; selSeq[3] = 3'd4;
        mag = m0;
        neg = n0;
        update = 1'b1;
        shown = tear ? ((m1 / 100) * 100 + (m0 % 100)) : m0;
        for (int r = 1; r <= 10; r++) begin
            stepCycle();
            update = 1'b0;
            expSel = (r <= 8) ? selSeq[(r - 1) / 2] : 3'd0;
            checkOutput({tag, "_sel"}, 64'(selA), 64'(expSel));
            checkOutput({tag, "_busy"}, 64'(busyA), 64'(r <= 9));
            checkOutput({tag, "_done"}, 64'(doneA), 64'(r == 10));
            if (r < 10) begin
                checkOutput({tag, "_hold"}, 64'({hA5, hA4, hA3, hA2, hA1, hA0}), 64'(lastShownA));
            end else begin
                lastShownA = refHex(shown, n0, 1'b1);
                checkOutput({tag, "_hex"}, 64'({hA5, hA4, hA3, hA2, hA1, hA0}), 64'(lastShownA));
            end
            if (tear && r == 5) begin
                mag = m1;
            end
        end
    endtask

    // Bounded wait for B's next done pulse
    task automatic waitDoneB(output int cycles);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 64; i++) begin
            stepCycle();
            cycles++;
            if (doneB) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("doneB_wait", 64'(seen), 64'd1);
    endtask

    initial begin
        int doneCount;
        int busyCount;
        int gap;
        logic busyAt10, busyAt11;

        // Reset, release, then idle for five cycles
        reset = 1'b1;
        repeat (3) stepCycle();
        reset = 1'b0;
        repeat (5) stepCycle();
        checkOutput("rst_hexA", 64'({hA5, hA4, hA3, hA2, hA1, hA0}), 64'({42{1'b1}}));
        checkOutput("rst_hexB", 64'({hB5, hB4, hB3, hB2, hB1, hB0}), 64'({42{1'b1}}));
        checkOutput("rst_busy", 64'({busyA, busyB}), 64'd0);
        checkOutput("rst_done", 64'({doneA, doneB}), 64'd0);
        checkOutput("rst_sel", 64'({selA, selB}), 64'd0);

        // Directed values, including negative zero and a torn input
        applyStimulus("v1234", 1234, 1'b0, 1'b0, 0);
        applyStimulus("vneg7", 7, 1'b1, 1'b0, 0);
        applyStimulus("vzero", 0, 1'b0, 1'b0, 0);
        applyStimulus("vnegzero", 0, 1'b1, 1'b0, 0);
        applyStimulus("v1000", 1000, 1'b0, 1'b0, 0);
        applyStimulus("v1234", 1234, 1'b0, 1'b0, 0);
        applyStimulus("vtorn", 1234, 1'b0, 1'b1, 5678);

        // Random magnitudes and signs
        for (int i = 0; i < 20; i++) begin
            applyStimulus("rand", $urandom_range(0, 9999), 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        // Requests at t+3 and t+6 during a sweep coalesce into one extra sweep
        mag = 42;
        neg = 1'b0;
        update = 1'b1;
        doneCount = 0;
        busyAt10 = 1'b1;
        busyAt11 = 1'b0;
        for (int r = 1; r <= 30; r++) begin
            stepCycle();
            update = (r == 3 || r == 6);
            if (doneA) doneCount++;
            if (r == 10) busyAt10 = busyA;
            if (r == 11) busyAt11 = busyA;
        end
        update = 1'b0;
        checkOutput("coalesce_dones", 64'(doneCount), 64'd2);
        checkOutput("coalesce_gap", 64'(busyAt10), 64'd0);
        checkOutput("coalesce_rise", 64'(busyAt11), 64'd1);
        lastShownA = refHex(42, 1'b0, 1'b1);
        checkOutput("coalesce_hex", 64'({hA5, hA4, hA3, hA2, hA1, hA0}), 64'(lastShownA));

        // Reset asserted at t+5 of a sweep aborts it with no done
        mag = 9876;
        update = 1'b1;
        doneCount = 0;
        busyCount = 0;
        for (int r = 1; r <= 25; r++) begin
            stepCycle();
            update = 1'b0;
            reset = (r == 5);
            if (r == 6) begin
                checkOutput("abort_hex", 64'({hA5, hA4, hA3, hA2, hA1, hA0}), 64'({42{1'b1}}));
                checkOutput("abort_busy", 64'(busyA), 64'd0);
                checkOutput("abort_sel", 64'(selA), 64'd0);
            end
            if (r >= 6) begin
                if (doneA) doneCount++;
                if (busyA) busyCount++;
            end
        end
        checkOutput("abort_nodone", 64'(doneCount), 64'd0);
        checkOutput("abort_nopending", 64'(busyCount), 64'd0);
        lastShownA = {42{1'b1}};

        // Instance B: periodic sweeps every 16 cycles, zeros not blanked
        mag = 0;
        neg = 1'b0;
        waitDoneB(gap);
        waitDoneB(gap);
        checkOutput("refresh_period1", 64'(gap), 64'd16);
        checkOutput("noblank_zero", 64'({hB5, hB4, hB3, hB2, hB1, hB0}), 64'(refHex(0, 1'b0, 1'b0)));
        mag = 305;
        neg = 1'b1;
        waitDoneB(gap);
        checkOutput("refresh_period2", 64'(gap), 64'd16);
        waitDoneB(gap);
        checkOutput("noblank_305", 64'({hB5, hB4, hB3, hB2, hB1, hB0}), 64'(refHex(305, 1'b1, 1'b0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Sequential display front end for the seven-segment path. It sweeps the digit-select code into the upstream digit multiplexer and samples the returned BCD digit and sign. It decodes each digit to segments, applies leading-zero blanking, and commits all six HEX outputs in one cycle so the display never tears. A sweep starts on an explicit update request or on a periodic refresh tick.

## Interface
- REFRESH_CYCLES, default 500000: clk cycles between automatic sweeps (10 ms at 50 MHz); minimum 16.
- BLANK_ZEROS, default 1: 1 blanks leading zeros on hex3..hex1; 0 shows all four digits.
- clk, input, 1: single clock domain.
- reset, input, 1: synchronous, active-high.
- update, input, 1: sweep request; level sampled every cycle.
- digit, input, 4: BCD digit returned for the current sel.
- sign, input, 1: 1 means negative value.
- sel, output, 3: digit-select code driven to the multiplexer.
- hex0..hex5, output, 7 each: active-low segments, bit order {g,f,e,d,c,b,a}.
- busy, output, 1: a sweep is in progress.
- done, output, 1: one-cycle pulse when new hex values become visible.

## Operation
- Digit steps use sel codes, in order: 0 = ones, 1 = tens, 3 = hundreds, 4 = thousands. Code 2 is never driven.
- States:
  - IDLE: wait for a trigger.
  - SETTLE(k): drive sel for step k.
  - SAMPLE(k): capture digit into shadow[k]; capture sign as well when k = 0.
  - COMMIT: decode and register all outputs.
- Transitions: IDLE → SETTLE(0) on trigger; SETTLE(k) → SAMPLE(k); SAMPLE(k) → SETTLE(k+1) for k < 3; SAMPLE(3) → COMMIT; COMMIT → IDLE.
- Trigger is any of: update = 1, refresh tick, or pending flag set. It is evaluated only in IDLE.
- Refresh counter: free-running, 0 to REFRESH_CYCLES-1, wraps to 0. The tick is the cycle it equals REFRESH_CYCLES-1.
- Pending flag:
  - Set by update or tick in any non-IDLE state.
  - Cleared when IDLE accepts a trigger.
  - Multiple requests coalesce into one sweep.
- Decode (active low, {g..a}):
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10–15 → blank (1111111)
- Leading-zero blanking (BLANK_ZEROS = 1):
  - hex3 blank if thousands = 0.
  - hex2 blank if thousands and hundreds are both 0.
  - hex1 blank if thousands, hundreds and tens are all 0.
  - hex0 is never blanked.
- hex4 = 0111111 (minus) when the sampled sign = 1, including magnitude 0; otherwise blank.
- hex5 is always blank.
- Output mapping: hex0 = ones, hex1 = tens, hex2 = hundreds, hex3 = thousands.

## Timing
- Reset values: hex0..hex5 = 1111111, sel = 0, busy = 0, done = 0, pending = 0, refresh counter = 0, state IDLE.
- Trigger accepted in IDLE at cycle t. Then:
  - SETTLE(k) at cycle t+1+2k, SAMPLE(k) at cycle t+2+2k.
  - sel holds each code for two cycles, starting at t+1.
  - COMMIT at t+9.
  - hex outputs and done = 1 at t+10.
- busy = 1 during t+1 through t+9.
- Upstream must present a valid digit within one cycle of a sel change; combinational or one-register upstream is allowed.
- sel returns to 0 in IDLE.
- A pending sweep begins at t+11 (IDLE at t+10 accepts it), so back-to-back sweeps run every 10 cycles.
- Reset asserted mid-sweep: the sweep aborts immediately, outputs return to reset values on the next edge, no done is produced, and pending is cleared.
- Shadow registers never reach the outputs outside COMMIT.

## Structure
- Package hex_display_pkg holds:
  - State enum.
  - Constants SEL_ONES = 3'd0, SEL_TENS = 3'd1, SEL_HUNDREDS = 3'd3, SEL_THOUSANDS = 3'd4.
  - SEG_BLANK = 7'b1111111 and SEG_MINUS = 7'b0111111.
  - Step-to-sel lookup function.
- Sub-module seg_decoder: combinational 4-bit BCD to 7-bit active-low segments, blank for 10–15. Instantiate it four times at COMMIT, or once per SAMPLE feeding shadow segment registers.

## Test plan
- Reset, then hold 5 cycles → hex0..5 = 1111111, busy = 0, done = 0, sel = 0.
- Reference multiplexer model with num = 1234, update pulse at t → sel = 0, 1, 3, 4 starting at t+1, t+3, t+5, t+7. At t+10: hex0 = 0011001, hex1 = 0110000, hex2 = 0100100, hex3 = 1111001, hex4 = hex5 = 1111111, done high for one cycle.
- num = -7 (13'h1FF9) → hex0 = 1111000, hex1..3 = 1111111, hex4 = 0111111.
- num = 0 → hex0 = 1000000, hex1..3 blank. With BLANK_ZEROS = 0 → hex1..3 = 1000000.
- Value changes from 1234 to 5678 between SAMPLE(1) and SAMPLE(2) → hex stays 1234 until t+10, then shows 5634 (torn input committed atomically).
- update pulses at t+3 and t+6 with REFRESH_CYCLES = 16 → exactly one extra sweep, busy rising at t+11. With no update, sweeps recur every 16 cycles. Reset at t+5 of a sweep → outputs blank, no done.
